// File: rtl/spi_flash_pkg.sv
// Shared constants and types for the SPI NOR-flash responder.
package spi_flash_pkg;

   // Supported flash opcodes
   localparam logic [7:0] OP_READ     = 8'h03;
   localparam logic [7:0] OP_PROGRAM  = 8'h02;
   localparam logic [7:0] OP_WREN     = 8'h06;
   localparam logic [7:0] OP_WRDI     = 8'h04;
   localparam logic [7:0] OP_RDSR     = 8'h05;
   localparam logic [7:0] OP_JEDEC_ID = 8'h9F;

   // JEDEC identification bytes (manufacturer, memory type, capacity)
   localparam logic [7:0] JEDEC_MFR  = 8'hEF;
   localparam logic [7:0] JEDEC_TYPE = 8'h40;
   localparam logic [7:0] JEDEC_CAP  = 8'h18;

   // Status register bit positions
   localparam int unsigned STATUS_WIP_BIT = 0;
   localparam int unsigned STATUS_WEL_BIT = 1;

   typedef enum logic [2:0] {
      StIdle,
      StCmd,
      StAddr,
      StRdData,
      StPgData,
      StStatus,
      StIgnore,
      StId
   } state_e;

   // ID byte for a given position; reads past the third byte return zero
   function automatic logic [7:0] jedec_byte(input logic [1:0] idx);
      unique case (idx)
         2'd0:    return JEDEC_MFR;
         2'd1:    return JEDEC_TYPE;
         2'd2:    return JEDEC_CAP;
         default: return 8'h00;
      endcase
   endfunction

endpackage

// File: rtl/spi_flash_responder_if.sv
// Word-wide memory port used by the flash responder to reach its backing store.
interface spi_flash_responder_if #(
   parameter int unsigned ADDR_W = 24
) ();
   logic              mem_req;
   logic              mem_we;
   logic [ADDR_W-3:0] mem_addr;
   logic [31:0]       mem_wdata;
   logic [3:0]        mem_be;
   logic [31:0]       mem_rdata;
   logic              mem_valid;

   modport master (
      output mem_req, mem_we, mem_addr, mem_wdata, mem_be,
      input  mem_rdata, mem_valid
   );

   modport slave (
      input  mem_req, mem_we, mem_addr, mem_wdata, mem_be,
      output mem_rdata, mem_valid
   );
endinterface

// File: rtl/spi_pin_sync.sv
// Synchronizes the SPI pins into clk and produces SCK/CS_N edge pulses.
// SYNC_STAGES must be at least 2.
module spi_pin_sync #(
   parameter int unsigned SYNC_STAGES = 2
) (
   input  logic clk,
   input  logic rst,
   input  logic cs_n_i,
   input  logic sck_i,
   input  logic mosi_i,
   output logic mosi_o,
   output logic sck_rise_o,
   output logic sck_fall_o,
   output logic cs_rise_o,
   output logic cs_fall_o
);
   logic [SYNC_STAGES-1:0] cs_q, sck_q, mosi_q;
   logic                   cs_prev_q, sck_prev_q;

   // Synchronizer chains plus one history flop for edge detection. CS_N resets
   // as "selected" so a frame already open at reset release never shows a fall.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cs_q       <= '0;
         sck_q      <= '0;
         mosi_q     <= '0;
         cs_prev_q  <= 1'b0;
         sck_prev_q <= 1'b0;
      end else begin
         cs_q       <= {cs_q[SYNC_STAGES-2:0], cs_n_i};
         sck_q      <= {sck_q[SYNC_STAGES-2:0], sck_i};
         mosi_q     <= {mosi_q[SYNC_STAGES-2:0], mosi_i};
         cs_prev_q  <= cs_q[SYNC_STAGES-1];
         sck_prev_q <= sck_q[SYNC_STAGES-1];
      end
   end

   assign mosi_o     = mosi_q[SYNC_STAGES-1];
   assign sck_rise_o = sck_q[SYNC_STAGES-1] & ~sck_prev_q;
   assign sck_fall_o = ~sck_q[SYNC_STAGES-1] & sck_prev_q;
   assign cs_rise_o  = cs_q[SYNC_STAGES-1] & ~cs_prev_q;
   assign cs_fall_o  = ~cs_q[SYNC_STAGES-1] & cs_prev_q;
endmodule

// File: rtl/spi_flash_responder.sv
// SPI mode-0 serial NOR flash responder serving commands from a 32-bit word memory.
// Optional JEDEC ID (0x9F) support: define SPI_FLASH_RESPONDER_JEDEC_ID_EN.
module spi_flash_responder
   import spi_flash_pkg::*;
#(
   parameter int unsigned ADDR_W          = 24,
   parameter int unsigned SYNC_STAGES     = 2,
   parameter int unsigned STATUS_WIP_HOLD = 0
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         spi_cs_n,
   input  logic                         spi_sck,
   input  logic                         spi_mosi,
   output logic                         spi_miso,
   spi_flash_responder_if.master        mem,
   output logic                         busy,
   output logic                         cmd_err
);
   localparam logic [7:0] HoldInit = 8'(STATUS_WIP_HOLD);

   logic mosi_s, sck_rise, sck_fall, cs_rise, cs_fall;

   spi_pin_sync #(
      .SYNC_STAGES(SYNC_STAGES)
   ) u_sync (
      .clk        (clk),
      .rst        (rst),
      .cs_n_i     (spi_cs_n),
      .sck_i      (spi_sck),
      .mosi_i     (spi_mosi),
      .mosi_o     (mosi_s),
      .sck_rise_o (sck_rise),
      .sck_fall_o (sck_fall),
      .cs_rise_o  (cs_rise),
      .cs_fall_o  (cs_fall)
   );

   state_e            state_q, state_d;
   logic [4:0]        cnt_q, cnt_d;
   logic [7:0]        shift_q, shift_d, tx_q, tx_d, hold_q, hold_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [31:0]       word_q, word_d, wdata_q, wdata_d;
   logic [ADDR_W-3:0] maddr_q, maddr_d;
   logic [3:0]        be_q, be_d;
   logic [1:0]        id_q, id_d;
   logic              miso_q, miso_d, wel_q, wel_d, prog_q, prog_d, pgcmd_q, pgcmd_d;
   logic              req_q, req_d, we_q, we_d, err_q, err_d;

   logic [7:0]        in_byte, out_src, status;
   logic [ADDR_W-1:0] addr_shift, addr_inc;
   logic              wip, is_out;

   assign wip    = (req_q & we_q) | (hold_q != 8'd0);
   assign is_out = (state_q == StRdData) || (state_q == StStatus) || (state_q == StId);

   // State register and datapath flops
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= StIdle;   cnt_q   <= '0;   shift_q <= '0;   tx_q    <= '0;
         hold_q  <= '0;       addr_q  <= '0;   word_q  <= '0;   wdata_q <= '0;
         maddr_q <= '0;       be_q    <= '0;   id_q    <= '0;   miso_q  <= 1'b0;
         wel_q   <= 1'b0;     prog_q  <= 1'b0; pgcmd_q <= 1'b0; req_q   <= 1'b0;
         we_q    <= 1'b0;     err_q   <= 1'b0;
      end else begin
         state_q <= state_d;  cnt_q   <= cnt_d;   shift_q <= shift_d;  tx_q    <= tx_d;
         hold_q  <= hold_d;   addr_q  <= addr_d;  word_q  <= word_d;   wdata_q <= wdata_d;
         maddr_q <= maddr_d;  be_q    <= be_d;    id_q    <= id_d;     miso_q  <= miso_d;
         wel_q   <= wel_d;    prog_q  <= prog_d;  pgcmd_q <= pgcmd_d;  req_q   <= req_d;
         we_q    <= we_d;     err_q   <= err_d;
      end
   end

   // Next-state: memory completion, MISO shifting on SCK fall, decode on SCK rise
   always_comb begin
      state_d = state_q;  cnt_d   = cnt_q;   shift_d = shift_q;  tx_d    = tx_q;
      hold_d  = hold_q;   addr_d  = addr_q;  word_d  = word_q;   wdata_d = wdata_q;
      maddr_d = maddr_q;  be_d    = be_q;    id_d    = id_q;     miso_d  = miso_q;
      wel_d   = wel_q;    prog_d  = prog_q;  pgcmd_d = pgcmd_q;  req_d   = req_q;
      we_d    = we_q;     err_d   = 1'b0;

      in_byte    = {shift_q[6:0], mosi_s};
      addr_shift = {addr_q[ADDR_W-2:0], mosi_s};
      addr_inc   = addr_q + ADDR_W'(1);

      status                 = 8'h00;
      status[STATUS_WEL_BIT] = wel_q;
      status[STATUS_WIP_BIT] = wip;

      case (state_q)
         StRdData: out_src = word_q[{addr_q[1:0], 3'b000} +: 8];
         StStatus: out_src = status;
         StId:     out_src = jedec_byte(id_q);
         default:  out_src = 8'h00;
      endcase

      // mem_valid without an outstanding request is ignored
      if (req_q && mem.mem_valid) begin
         req_d = 1'b0;
         if (we_q) hold_d = HoldInit;
         else      word_d = mem.mem_rdata;
      end else if (hold_q != 8'd0) begin
         hold_d = hold_q - 8'd1;
      end

      if (sck_fall && is_out) begin
         if (cnt_q[2:0] == 3'd0) begin
            miso_d = out_src[7];
            tx_d   = {out_src[6:0], 1'b0};
         end else begin
            miso_d = tx_q[7];
            tx_d   = {tx_q[6:0], 1'b0};
         end
      end
      if (!is_out) miso_d = 1'b0;

      if (sck_rise && !cs_rise) begin
         shift_d = in_byte;
         cnt_d   = cnt_q + 5'd1;
         case (state_q)
            StCmd: begin
               if (cnt_q == 5'd7) begin
                  cnt_d   = '0;
                  state_d = StIgnore;
                  case (in_byte)
                     OP_READ: begin
                        state_d = StAddr;
                        pgcmd_d = 1'b0;
                     end
                     OP_PROGRAM: begin
                        if (wel_q) begin
                           state_d = StAddr;
                           pgcmd_d = 1'b1;
                        end else begin
                           err_d = 1'b1;
                        end
                     end
                     OP_WREN: wel_d   = 1'b1;
                     OP_WRDI: wel_d   = 1'b0;
                     OP_RDSR: state_d = StStatus;
`ifdef SPI_FLASH_RESPONDER_JEDEC_ID_EN
                     OP_JEDEC_ID: state_d = StId;
`endif
                     default: err_d = 1'b1;
                  endcase
               end
            end
            StAddr: begin
               addr_d = addr_shift;
               if (cnt_q == 5'd23) begin
                  cnt_d   = '0;
                  state_d = pgcmd_q ? StPgData : StRdData;
                  if (!req_q) begin
                     req_d   = 1'b1;
                     we_d    = 1'b0;
                     be_d    = 4'hF;
                     maddr_d = addr_shift[ADDR_W-1:2];
                  end
               end
            end
            StRdData: begin
               if (cnt_q[2:0] == 3'd7) begin
                  cnt_d  = '0;
                  addr_d = addr_inc;
                  // Crossing into the next word: prefetch it before the next byte shifts out
                  if (addr_inc[1:0] == 2'd0 && !req_q) begin
                     req_d   = 1'b1;
                     we_d    = 1'b0;
                     be_d    = 4'hF;
                     maddr_d = addr_inc[ADDR_W-1:2];
                  end
               end
            end
            StPgData: begin
               if (cnt_q[2:0] == 3'd7) begin
                  cnt_d = '0;
                  if (req_q) begin
                     err_d = 1'b1;
                  end else begin
                     req_d   = 1'b1;
                     we_d    = 1'b1;
                     be_d    = 4'b0001 << addr_q[1:0];
                     wdata_d = {4{in_byte}};
                     maddr_d = addr_q[ADDR_W-1:2];
                     addr_d  = addr_inc;
                     prog_d  = 1'b1;
                  end
               end
            end
            StStatus, StIgnore: begin
               if (cnt_q[2:0] == 3'd7) cnt_d = '0;
            end
            StId: begin
               if (cnt_q[2:0] == 3'd7) begin
                  cnt_d = '0;
                  if (id_q != 2'd3) id_d = id_q + 2'd1;
               end
            end
            default: ;
         endcase
      end

      if (state_q == StIdle) begin
         if (cs_fall) begin
            state_d = StCmd;
            cnt_d   = '0;
            id_d    = '0;
         end
      end else if (cs_rise) begin
         state_d = StIdle;
         cnt_d   = '0;
         miso_d  = 1'b0;
         prog_d  = 1'b0;
         if (prog_q) wel_d = 1'b0;
      end
   end

   assign spi_miso      = miso_q;
   assign mem.mem_req   = req_q;
   assign mem.mem_we    = we_q;
   assign mem.mem_addr  = maddr_q;
   assign mem.mem_wdata = wdata_q;
   assign mem.mem_be    = be_q;
   assign busy          = (state_q != StIdle) | req_q;
   assign cmd_err       = err_q;
endmodule

// File: tb/tb_spi_flash_responder.sv
// Directed self-checking bench for spi_flash_responder with a small word-memory model.
module tb_spi_flash_responder;
   localparam int HALF = 10;

   logic clk = 1'b0;
   logic rst, spi_cs_n, spi_sck, spi_mosi;
   logic spi_miso, busy, cmd_err;

   always #5 clk = ~clk;

   spi_flash_responder_if #(.ADDR_W(24)) mem_if ();

   spi_flash_responder #(
      .ADDR_W          (24),
      .SYNC_STAGES     (2),
      .STATUS_WIP_HOLD (0)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .spi_cs_n (spi_cs_n),
      .spi_sck  (spi_sck),
      .spi_mosi (spi_mosi),
      .spi_miso (spi_miso),
      .mem      (mem_if),
      .busy     (busy),
      .cmd_err  (cmd_err)
   );

   int n_checks = 0;
   int n_fail   = 0;

   bit [31:0]   mem_arr [int];
   int          rd_cnt = 0, wr_cnt = 0, err_cnt = 0, lat = 0;
   logic [21:0] last_rd_addr;
   logic [21:0] wr_addr [0:15];
   logic [3:0]  wr_be   [0:15];
   logic [31:0] wr_data [0:15];

   // Memory model: answers each request two cycles after it is seen, logs traffic
   always @(posedge clk) begin
      mem_if.mem_valid <= 1'b0;
      if (cmd_err) err_cnt <= err_cnt + 1;
      if (rst) begin
         lat <= 0;
      end else if (mem_if.mem_req && !mem_if.mem_valid) begin
         if (lat == 1) begin
            lat              <= 0;
            mem_if.mem_valid <= 1'b1;
            if (mem_if.mem_we) begin
               wr_addr[wr_cnt % 16] <= mem_if.mem_addr;
               wr_be[wr_cnt % 16]   <= mem_if.mem_be;
               wr_data[wr_cnt % 16] <= mem_if.mem_wdata;
               wr_cnt               <= wr_cnt + 1;
            end else begin
               if (mem_arr.exists(int'(mem_if.mem_addr)))
                  mem_if.mem_rdata <= mem_arr[int'(mem_if.mem_addr)];
               else
                  mem_if.mem_rdata <= 32'h0;
               last_rd_addr <= mem_if.mem_addr;
               rd_cnt       <= rd_cnt + 1;
            end
         end else begin
            lat <= lat + 1;
         end
      end
   end

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic xfer(input logic [7:0] tx, output logic [7:0] rx);
      for (int i = 7; i >= 0; i--) begin
         spi_mosi = tx[i];
         repeat (HALF) @(negedge clk);
         rx[i]   = spi_miso;
         spi_sck = 1'b1;
         repeat (HALF) @(negedge clk);
         spi_sck = 1'b0;
      end
   endtask

   task automatic xfer_bits(input int n);
      for (int i = 0; i < n; i++) begin
         spi_mosi = 1'b0;
         repeat (HALF) @(negedge clk);
         spi_sck = 1'b1;
         repeat (HALF) @(negedge clk);
         spi_sck = 1'b0;
      end
   endtask

   task automatic cs_open();
      spi_cs_n = 1'b0;
      repeat (HALF) @(negedge clk);
   endtask

   task automatic cs_close();
      repeat (HALF) @(negedge clk);
      spi_cs_n = 1'b1;
      repeat (2 * HALF) @(negedge clk);
   endtask

   initial begin
      #5000000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      logic [7:0] rx, acc;
      logic [7:0] exp_rd [0:4];
      logic [7:0] exp_id [0:3];
      int r0, w0, e0, exp_id_err;

      rst      = 1'b1;
      spi_cs_n = 1'b1;
      spi_sck  = 1'b0;
      spi_mosi = 1'b0;
      mem_arr[32'h100]    = 32'hDDCCBBAA;
      mem_arr[32'h101]    = 32'h44332211;
      mem_arr[32'h3FFFFF] = 32'h5A000000;
      mem_arr[32'h0]      = 32'h000000C3;

      repeat (4) @(negedge clk);
      check_eq("rst_miso", spi_miso, 0);
      check_eq("rst_req_we", {mem_if.mem_req, mem_if.mem_we}, 0);
      check_eq("rst_addr", mem_if.mem_addr, 0);
      check_eq("rst_wdata_be", {mem_if.mem_wdata, mem_if.mem_be}, 0);
      check_eq("rst_busy_err", {busy, cmd_err}, 0);
      rst = 1'b0;
      repeat (2 * HALF) @(negedge clk);

      // Sequential read across a word boundary
      exp_rd[0] = 8'hAA; exp_rd[1] = 8'hBB; exp_rd[2] = 8'hCC;
      exp_rd[3] = 8'hDD; exp_rd[4] = 8'h11;
      r0 = rd_cnt;
      cs_open();
      xfer(8'h03, rx); xfer(8'h00, rx); xfer(8'h04, rx); xfer(8'h00, rx);
      for (int i = 0; i < 5; i++) begin
         xfer(8'h00, rx);
         check_eq($sformatf("read_byte%0d", i), rx, exp_rd[i]);
      end
      check_eq("read_busy", busy, 1);
      cs_close();
      check_eq("read_count", rd_cnt - r0, 2);
      check_eq("read_last_addr", last_rd_addr, 22'h101);

      // WREN then program two bytes at byte address 5 (word 1, lanes 1 and 2)
      r0 = rd_cnt; w0 = wr_cnt; e0 = err_cnt;
      cs_open(); xfer(8'h06, rx); cs_close();
      cs_open();
      xfer(8'h02, rx); xfer(8'h00, rx); xfer(8'h00, rx); xfer(8'h05, rx);
      xfer(8'h11, rx); xfer(8'h22, rx);
      cs_close();
      check_eq("prog_writes", wr_cnt - w0, 2);
      check_eq("prog_reads", rd_cnt - r0, 1);
      check_eq("prog_err", err_cnt - e0, 0);
      check_eq("prog_w0_addr", wr_addr[w0 % 16], 22'h1);
      check_eq("prog_w0_be", wr_be[w0 % 16], 4'b0010);
      check_eq("prog_w0_data", wr_data[w0 % 16], 32'h11111111);
      check_eq("prog_w1_addr", wr_addr[(w0 + 1) % 16], 22'h1);
      check_eq("prog_w1_be", wr_be[(w0 + 1) % 16], 4'b0100);
      check_eq("prog_w1_data", wr_data[(w0 + 1) % 16], 32'h22222222);
      cs_open(); xfer(8'h05, rx); xfer(8'h00, rx); cs_close();
      check_eq("rdsr_after_prog", rx, 8'h00);

      // PROGRAM without WEL is rejected
      r0 = rd_cnt; w0 = wr_cnt; e0 = err_cnt; acc = 8'h00;
      cs_open();
      xfer(8'h02, rx); acc |= rx; xfer(8'h00, rx); acc |= rx; xfer(8'h00, rx); acc |= rx;
      xfer(8'h00, rx); acc |= rx; xfer(8'h11, rx); acc |= rx;
      cs_close();
      check_eq("noprog_err", err_cnt - e0, 1);
      check_eq("noprog_mem", (rd_cnt - r0) + (wr_cnt - w0), 0);
      check_eq("noprog_miso", acc, 8'h00);

      // Read wraps from the top byte address to zero
      r0 = rd_cnt;
      cs_open();
      xfer(8'h03, rx); xfer(8'hFF, rx); xfer(8'hFF, rx); xfer(8'hFF, rx);
      xfer(8'h00, rx); check_eq("wrap_top", rx, 8'h5A);
      xfer(8'h00, rx); check_eq("wrap_zero", rx, 8'hC3);
      cs_close();
      check_eq("wrap_reads", rd_cnt - r0, 2);
      check_eq("wrap_last_addr", last_rd_addr, 22'h0);

      // WREN visible in status, WRDI clears it
      cs_open(); xfer(8'h06, rx); cs_close();
      cs_open(); xfer(8'h05, rx); xfer(8'h00, rx);
      check_eq("rdsr_wel", rx, 8'h02);
      xfer(8'h00, rx);
      check_eq("rdsr_repeat", rx, 8'h02);
      cs_close();
      cs_open(); xfer(8'h04, rx); cs_close();
      cs_open(); xfer(8'h05, rx); xfer(8'h00, rx); cs_close();
      check_eq("rdsr_wrdi", rx, 8'h00);

      // Aborted address phase issues no memory request
      r0 = rd_cnt;
      cs_open(); xfer(8'h03, rx); xfer(8'h00, rx); xfer(8'h00, rx); xfer_bits(4); cs_close();
      check_eq("abort_reads", rd_cnt - r0, 0);
      check_eq("abort_idle", {busy, mem_if.mem_req}, 0);

      // JEDEC ID
`ifdef SPI_FLASH_RESPONDER_JEDEC_ID_EN
      exp_id[0] = 8'hEF; exp_id[1] = 8'h40; exp_id[2] = 8'h18; exp_id[3] = 8'h00;
      exp_id_err = 0;
`else
      exp_id[0] = 8'h00; exp_id[1] = 8'h00; exp_id[2] = 8'h00; exp_id[3] = 8'h00;
      exp_id_err = 1;
`endif
      e0 = err_cnt;
      cs_open();
      xfer(8'h9F, rx);
      for (int i = 0; i < 4; i++) begin
         xfer(8'h00, rx);
         check_eq($sformatf("jedec_byte%0d", i), rx, exp_id[i]);
      end
      cs_close();
      check_eq("jedec_err", err_cnt - e0, exp_id_err);

      // Reset in the middle of a READ while CS_N stays low
      cs_open(); xfer(8'h06, rx); cs_close();
      cs_open();
      xfer(8'h03, rx); xfer(8'h00, rx); xfer(8'h04, rx); xfer(8'h00, rx);
      xfer(8'h00, rx);
      check_eq("midrst_first", rx, 8'hAA);
      rst = 1'b1;
      repeat (4) @(negedge clk);
      check_eq("midrst_miso", spi_miso, 0);
      check_eq("midrst_req_busy", {mem_if.mem_req, busy, cmd_err}, 0);
      rst = 1'b0;
      repeat (4) @(negedge clk);
      e0 = err_cnt;
      xfer(8'h06, rx);
      xfer(8'hA5, rx);
      check_eq("midrst_ignored_busy", busy, 0);
      check_eq("midrst_ignored_err", err_cnt - e0, 0);
      cs_close();
      cs_open(); xfer(8'h05, rx); xfer(8'h00, rx); cs_close();
      check_eq("midrst_rdsr", rx, 8'h00);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
